// File: rtl/lb_router_pkg.sv
// Local-bus router shared types, default widths and address field helpers.
package XT_LBUS_Pkg;

    localparam int LB_ADDR_W = 8;
    localparam int LB_ID_W   = 2;
    localparam int LB_DATA_W = 32;
    localparam int LB_WW_W   = 2;
    localparam int LB_TMO    = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lb_state_t;

    typedef struct packed {
        logic                 we;
        logic [LB_WW_W-1:0]   width;
        logic [LB_DATA_W-1:0] wdata;
    } lb_slave_t;

    // Callers cast the result down to their own ID/offset width.
    function automatic logic [31:0] lb_id(
        input logic [31:0] addr,
        input int          aw,
        input int          iw
    );
        return (addr >> (aw - iw)) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] lb_offset(
        input logic [31:0] addr,
        input int          aw,
        input int          iw
    );
        return addr & ((32'd1 << (aw - iw)) - 32'd1);
    endfunction

endpackage

// File: rtl/lb_router_timeout_counter.sv
// ACCESS-phase watchdog: counts stalled cycles, flags expiry at TIMEOUT.
module lb_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lb_router.sv
// Local-bus master-to-slave router with unmapped-ID error response.
// Define LB_TIMEOUT_EN to abort stalled ACCESS phases after TIMEOUT cycles.
module lb_router
    import XT_LBUS_Pkg::*;
#(
    parameter int                    ADDR_WIDTH = LB_ADDR_W,
    parameter int                    ID_WIDTH   = LB_ID_W,
    parameter logic [2**ID_WIDTH-1:0] SLAVE_MASK = '1,
    parameter int                    TIMEOUT    = LB_TMO
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_req,
    input  logic                             m_we,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [1:0]                       m_write_width,
    input  logic [31:0]                      m_wdata,
    output logic                             m_ready,
    output logic [31:0]                      m_rdata,
    output logic                             m_err,
    output logic [2**ID_WIDTH-1:0]           s_sel,
    output logic                             s_we,
    output logic [ADDR_WIDTH-ID_WIDTH-1:0]   s_addr,
    output logic [1:0]                       s_write_width,
    output logic [31:0]                      s_wdata,
    input  logic [(2**ID_WIDTH)*32-1:0]      s_rdata,
    input  logic [2**ID_WIDTH-1:0]           s_ready
);

    localparam int NSLV  = 2**ID_WIDTH;
    localparam int OFS_W = ADDR_WIDTH - ID_WIDTH;

    lb_state_t           r_state;
    lb_slave_t           r_cmd;
    logic [ID_WIDTH-1:0] r_id;
    logic [OFS_W-1:0]    r_ofs;
    logic [NSLV-1:0]     r_sel;
    logic                r_ready;
    logic                r_err;
    logic [31:0]         r_rdata;

    logic [ID_WIDTH-1:0] w_id;
    logic [OFS_W-1:0]    w_ofs;
    logic                w_hit;
    logic                w_expire;
    logic [31:0]         w_rd;

    assign w_id  = ID_WIDTH'(lb_id(32'(m_addr), ADDR_WIDTH, ID_WIDTH));
    assign w_ofs = OFS_W'(lb_offset(32'(m_addr), ADDR_WIDTH, ID_WIDTH));
    // Only the latched target's handshake is observed.
    assign w_hit = s_ready[r_id];
    assign w_rd  = s_rdata[r_id*32 +: 32];

`ifdef LB_TIMEOUT_EN
    lb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state != ST_ACCESS),
        .i_enable ((r_state == ST_ACCESS) && !w_hit),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_id    <= '0;
            r_ofs   <= '0;
            r_sel   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (m_req) begin
                        r_id        <= w_id;
                        r_ofs       <= w_ofs;
                        r_cmd.we    <= m_we;
                        r_cmd.width <= m_write_width;
                        r_cmd.wdata <= m_wdata;
                        if (SLAVE_MASK[w_id]) begin
                            r_sel   <= NSLV'(1) << w_id;
                            r_state <= ST_ACCESS;
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_hit) begin
                        r_rdata <= r_cmd.we ? 32'd0 : w_rd;
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                        r_sel   <= '0;
                        r_state <= ST_RESP;
                    end else if (w_expire) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_sel   <= '0;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sel   <= '0;
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ready       = r_ready;
    assign m_rdata       = r_rdata;
    assign m_err         = r_err;
    assign s_sel         = r_sel;
    assign s_we          = r_cmd.we;
    assign s_addr        = r_ofs;
    assign s_write_width = r_cmd.width;
    assign s_wdata       = r_cmd.wdata;

endmodule

// File: tb/tb_lb_router.sv
// Self-checking bench for lb_router: vector table, scoreboard, corner sequences.
module tb_lb_router;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         m_req = 1'b0;
    logic         m_we = 1'b0;
    logic [7:0]   m_addr = '0;
    logic [1:0]   m_write_width = '0;
    logic [31:0]  m_wdata = '0;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic         m_err;
    logic [3:0]   s_sel;
    logic         s_we;
    logic [5:0]   s_addr;
    logic [1:0]   s_write_width;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;

    always #5 clk = ~clk;

    lb_router #(
        .ADDR_WIDTH (8),
        .ID_WIDTH   (2),
        .SLAVE_MASK (4'b0111),
        .TIMEOUT    (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m_req         (m_req),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_write_width (m_write_width),
        .m_wdata       (m_wdata),
        .m_ready       (m_ready),
        .m_rdata       (m_rdata),
        .m_err         (m_err),
        .s_sel         (s_sel),
        .s_we          (s_we),
        .s_addr        (s_addr),
        .s_write_width (s_write_width),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_ready       (s_ready)
    );

    // Slave model: selected slave answers after sl_wait stalled cycles;
    // unselected slaves drive junk data and noise on s_ready.
    int          sl_wait  = 0;
    int          sl_cnt   = 0;
    bit          sl_never = 1'b0;
    logic [3:0]  noise    = '0;
    logic [31:0] sl_rd    = '0;

    always @(posedge clk) sl_cnt <= (|s_sel) ? sl_cnt + 1 : 0;

    always_comb begin
        s_ready = ~s_sel & noise;
        if (!sl_never && sl_cnt == sl_wait) s_ready = s_ready | s_sel;
        s_rdata = '0;
        for (int i = 0; i < 4; i++)
            s_rdata[i*32 +: 32] = s_sel[i] ? sl_rd : (32'hBAD0_0000 | 32'(i));
    end

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_run   = 0;
    int   n_fail  = 0;
    int   n_ready = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (m_ready === 1'b1) begin
            n_ready++;
            if (q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_ready: got m_ready=1 want 0 at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("m_rdata", m_rdata, e.rd);
                chk("m_err", 32'(m_err), 32'(e.err));
            end
        end
    end

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [1:0]  width;
        logic [31:0] wdata;
        int          wt;
        logic [31:0] rd;
        logic [3:0]  noise;
        logic [3:0]  exp_sel;
        logic [5:0]  exp_ofs;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic run_vec(input vec_t v);
        int sel_cyc;
        int lat;
        int exp_lat;
        @(negedge clk);
        sl_wait  = v.wt;
        sl_rd    = v.rd;
        noise    = v.noise;
        sl_never = 1'b0;
        m_req    = 1'b1;
        m_we     = v.we;
        m_addr   = v.addr;
        m_write_width = v.width;
        m_wdata  = v.wdata;
        @(posedge clk);
        q.push_back('{rd: v.exp_rd, err: v.exp_err});
        sel_cyc = 0;
        lat     = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (s_sel != 4'b0) begin
                sel_cyc++;
                chk("s_sel", 32'(s_sel), 32'(v.exp_sel));
                chk("s_addr", 32'(s_addr), 32'(v.exp_ofs));
                chk("s_we", 32'(s_we), 32'(v.we));
                chk("s_wdata", s_wdata, v.wdata);
                chk("s_width", 32'(s_write_width), 32'(v.width));
            end
            if (m_ready) begin
                lat   = k;
                m_req = 1'b0;
            end else begin
                m_addr = 8'($urandom);
                m_wdata = $urandom;
                m_we = 1'($urandom);
                m_write_width = 2'($urandom);
            end
        end
        exp_lat = (v.exp_sel == 4'b0) ? 1 : v.wt + 2;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("sel_cycles", 32'(sel_cyc), (v.exp_sel == 4'b0) ? 32'd0 : 32'(v.wt + 1));
        @(negedge clk);
        chk("ready_pulse", 32'(m_ready), 32'd0);
        chk("rdata_hold", m_rdata, v.exp_rd);
    endtask

    initial begin : main
        int r0;
        int p1;
        int p2;
        int sel_cyc;
        int lat;

        tbl[0] = '{8'h45, 1'b0, 2'd0, 32'h0,        0, 32'hDEADBEEF, 4'h0,
                   4'b0010, 6'h05, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{8'h82, 1'b1, 2'd2, 32'h12345678, 3, 32'hFFFF0000, 4'h0,
                   4'b0100, 6'h02, 32'h0,        1'b0};
        tbl[2] = '{8'hC0, 1'b0, 2'd0, 32'h0,        0, 32'hDEADBEEF, 4'h0,
                   4'b0000, 6'h00, 32'h0,        1'b1};
        tbl[3] = '{8'h3F, 1'b0, 2'd1, 32'h0,        1, 32'hCAFEF00D, 4'h0,
                   4'b0001, 6'h3F, 32'hCAFEF00D, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 2'd3, 32'h55AA55AA, 0, 32'h0,        4'h0,
                   4'b0000, 6'h00, 32'h0,        1'b1};
        tbl[5] = '{8'h7E, 1'b1, 2'd1, 32'hA5A5A5A5, 0, 32'h11112222, 4'h0,
                   4'b0010, 6'h3E, 32'h0,        1'b0};
        tbl[6] = '{8'h80, 1'b0, 2'd0, 32'h0,        2, 32'h13579BDF, 4'b1011,
                   4'b0100, 6'h00, 32'h13579BDF, 1'b0};

        #12;
        chk("rst_s_sel", 32'(s_sel), 32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_we", 32'(s_we), 32'd0);
        chk("rst_s_addr", 32'(s_addr), 32'd0);
        chk("rst_s_width", 32'(s_write_width), 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Slave 0 never answers.
        @(negedge clk);
        noise    = '0;
        sl_never = 1'b1;
        m_req    = 1'b1;
        m_we     = 1'b0;
        m_addr   = 8'h00;
        @(posedge clk);
`ifdef LB_TIMEOUT_EN
        q.push_back('{rd: 32'h0, err: 1'b1});
        sel_cyc = 0;
        lat     = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (s_sel == 4'b0001) sel_cyc++;
            if (m_ready) begin
                lat   = k;
                m_req = 1'b0;
            end
        end
        chk("tmo_sel_cycles", 32'(sel_cyc), 32'd15);
        chk("tmo_latency", 32'(lat), 32'd16);
        sl_never = 1'b0;
`else
        r0 = n_ready;
        for (int k = 0; k < 100; k++) @(negedge clk);
        chk("hang_no_ready", 32'(n_ready - r0), 32'd0);
        chk("hang_s_sel", 32'(s_sel), 32'b0001);
        rst   = 1'b1;
        m_req = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        sl_never = 1'b0;
`endif

        // Reset in the second ACCESS cycle aborts the transfer.
        @(negedge clk);
        sl_never = 1'b1;
        m_req    = 1'b1;
        m_we     = 1'b0;
        m_addr   = 8'h40;
        @(posedge clk);
        r0 = n_ready;
        @(negedge clk);
        chk("abort_sel_pre", 32'(s_sel), 32'b0010);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_sel_async", 32'(s_sel), 32'd0);
        chk("abort_ready", 32'(m_ready), 32'd0);
        m_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        sl_never = 1'b0;
        @(negedge clk);
        chk("abort_no_ready", 32'(n_ready - r0), 32'd0);
        run_vec(tbl[0]);

        // m_req held through m_ready gives two back-to-back transfers.
        @(negedge clk);
        sl_wait = 0;
        sl_rd   = 32'h5A5A1234;
        noise   = '0;
        m_req   = 1'b1;
        m_we    = 1'b0;
        m_addr  = 8'h45;
        q.push_back('{rd: 32'h5A5A1234, err: 1'b0});
        q.push_back('{rd: 32'h5A5A1234, err: 1'b0});
        @(posedge clk);
        p1 = 0;
        p2 = 0;
        for (int k = 1; k <= 20 && p2 == 0; k++) begin
            @(negedge clk);
            if (m_ready) begin
                if (p1 == 0) begin
                    p1 = k;
                end else begin
                    p2    = k;
                    m_req = 1'b0;
                end
            end
        end
        m_req = 1'b0;
        chk("b2b_first", 32'(p1), 32'd2);
        chk("b2b_second", 32'(p2), 32'd5);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
